seq_mod_unit: RTL and testbench
===============================

// Module: seq_mod_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider. Produces remainder (result) and quotient of a/b.
//  Sits directly upstream of the ALU: result drives the ALU's mod-result input (alu_ctr=3'b111).
//  The controller holds the instruction until done pulses.
//  One quotient bit per cycle; start/busy/done handshake.
// PARAMETERS
//  WIDTH  32  operand, remainder and quotient width
//  CNT_W  6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  CLK          input   1      clock; all state changes on the rising edge
//  reset        input   1      synchronous, active-low reset
//  start        input   1      request; sampled only in IDLE or DONE
//  a            input   WIDTH  dividend; captured on an accepted start
//  b            input   WIDTH  divisor; captured on an accepted start
//  busy         output  1      high while in RUN
//  done         output  1      one-cycle pulse when result/quotient become valid
//  result       output  WIDTH  remainder; held until the next accepted start
//  quotient     output  WIDTH  quotient; held until the next accepted start
//  div_by_zero  output  1      set with done when the captured b==0
// BEHAVIOUR
//  - Reset (reset==0 at an edge): state=IDLE; busy, done, div_by_zero, result and quotient = 0.
//    Reset wins over every other event, including mid-RUN; the partial operation is discarded.
//  - States:
//    - IDLE: start=1 and b!=0 -> RUN.
//    - IDLE: start=1 and b==0 -> DONE.
//    - RUN: count==WIDTH-1 -> DONE.
//    - DONE: start=1 -> same as IDLE; else -> IDLE.
//    - DONE lasts exactly one cycle; done=1 only in DONE.
//  - Accept: a/b latched into internal regs; rem_acc=0; count=0; busy=1 from the next cycle.
//    result, quotient and div_by_zero clear to 0 on accept.
//  - RUN step per cycle, width WIDTH+1 internally:
//    - shift {rem_acc, dvd} left 1.
//    - trial = rem_acc - b.
//    - trial >= 0: rem_acc = trial, quotient bit = 1.
//    - otherwise: restore, quotient bit = 0.
//  - Latency: done is high in the cycle after edge k+WIDTH, where edge k accepts start
//    (WIDTH+1 cycles total, i.e. 33 for WIDTH=32). Outputs are valid in the same cycle as done.
//  - b==0: no RUN. done is high the cycle after the accepting edge. result=a,
//    quotient=all ones, div_by_zero=1.
//  - start while busy: ignored; no queueing; operands are not recaptured.
//  - start in DONE: accepted back-to-back. The done pulse still occurs and outputs clear on the next edge.
//  - a<b: result=a, quotient=0, full WIDTH+1 latency (no early exit).
// CONFIGURATION
//  MOD_SIGNED_EN defined:
//    - Operands are two's complement.
//    - Magnitudes are divided.
//    - Quotient is negated if sign(a)!=sign(b).
//    - Remainder takes the sign of a (MIPS div semantics).
//    - Sign fix-up is combinational on entry to DONE, so latency is unchanged.
//    - -2**(WIDTH-1)/-1 -> quotient=0x80000000, result=0.
//    - b==0 -> result=a, quotient=all ones.
//  MOD_SIGNED_EN undefined: all operands unsigned; no sign logic is synthesized.
// TESTING
//  1. a=100, b=7, start 1 cycle -> busy for 32 cycles; done at cycle 33; result=2, quotient=14, div_by_zero=0.
//  2. a=0x1234, b=0 -> done next cycle; result=0x1234, quotient=0xFFFFFFFF, div_by_zero=1; busy never high.
//  3. a=5, b=9 -> done at cycle 33; result=5, quotient=0. Then start held high during RUN with a=1, b=1
//     -> ignored; outputs stay 5/0.
//  4. Start a=1000, b=3; drive reset=0 at cycle 10 -> next edge busy=0, done=0, outputs=0.
//     Release reset, start a=9, b=4 -> cycle 33: result=1, quotient=2.
//  5. a=0xFFFFFFF9, b=3, MOD_SIGNED_EN undefined -> result=0, quotient=0x55555553.
//     Same stimulus with MOD_SIGNED_EN defined -> result=0xFFFFFFFF (-1), quotient=0xFFFFFFFE (-2).
//  6. Back-to-back: start asserted in the DONE cycle of test 1 with a=50, b=6 -> second done
//     33 cycles later; result=2, quotient=8.

Source files
------------

// File: rtl/seq_mod_unit.sv
// seq_mod_unit: multi-cycle radix-2 restoring divider producing remainder
// (result) and quotient of a/b, one quotient bit per cycle, start/busy/done
// handshake. Optional build macro MOD_SIGNED_EN selects two's-complement
// operands with MIPS-style sign fix-up; undefined gives a purely unsigned unit.
module seq_mod_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] quotient,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_acc;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dvd_step;
    logic [WIDTH-1:0] rem_fin;
    logic [WIDTH-1:0] quo_fin;
`ifdef MOD_SIGNED_EN
    logic             neg_q;
    logic             neg_r;
`endif

    // Handshake qualifiers: start only counts outside RUN
    always_comb begin
        accept    = (state != S_RUN) && start;
        last_step = (state == S_RUN) && (count == CNT_W'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    state_nxt = (b == '0) ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand magnitudes fed to the unsigned core
    always_comb begin
`ifdef MOD_SIGNED_EN
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
`else
        a_mag = a;
        b_mag = b;
`endif
    end

    // One restoring step; the borrow out of the WIDTH+1 trial picks keep/restore
    always_comb begin
        shifted = {rem_acc, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        if (!trial[WIDTH]) begin
            rem_step = trial[WIDTH-1:0];
            dvd_step = {dvd[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = shifted[WIDTH-1:0];
            dvd_step = {dvd[WIDTH-2:0], 1'b0};
        end
`ifdef MOD_SIGNED_EN
        quo_fin = neg_q ? -dvd_step : dvd_step;
        rem_fin = neg_r ? -rem_step : rem_step;
`else
        quo_fin = dvd_step;
        rem_fin = rem_step;
`endif
    end

    // Datapath: capture on accept, iterate in RUN, publish on the last step
    always_ff @(posedge CLK) begin
        if (!reset) begin
            dvd         <= '0;
            dvs         <= '0;
            rem_acc     <= '0;
            count       <= '0;
            result      <= '0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
`ifdef MOD_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else if (accept) begin
            dvd     <= a_mag;
            dvs     <= b_mag;
            rem_acc <= '0;
            count   <= '0;
`ifdef MOD_SIGNED_EN
            neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r   <= a[WIDTH-1];
`endif
            // Zero divisor skips RUN, so its outputs are published right here
            if (b == '0) begin
                result      <= a;
                quotient    <= '1;
                div_by_zero <= 1'b1;
            end else begin
                result      <= '0;
                quotient    <= '0;
                div_by_zero <= 1'b0;
            end
        end else if (state == S_RUN) begin
            rem_acc <= rem_step;
            dvd     <= dvd_step;
            count   <= count + CNT_W'(1);
            if (last_step) begin
                result   <= rem_fin;
                quotient <= quo_fin;
            end
        end
    end

endmodule

// File: tb/tb_seq_mod_unit.sv
// tb_seq_mod_unit: directed bench for seq_mod_unit with a latency/arithmetic
// reference model and a per-cycle compare process. Honours MOD_SIGNED_EN.
module tb_seq_mod_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] quotient;
    logic             div_by_zero;

    int n_err = 0;
    int n_chk = 0;
    logic chk_en = 1'b0;
    logic last_saw_busy;

    // Reference model state
    int               m_cd = 0;
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic             m_dbz = 1'b0;
    logic [WIDTH-1:0] m_res = '0;
    logic [WIDTH-1:0] m_quo = '0;
    logic [WIDTH-1:0] p_res = '0;
    logic [WIDTH-1:0] p_quo = '0;

    seq_mod_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .CLK         (clk),
        .reset       (rst_n),
        .start       (start),
        .a           (op_a),
        .b           (op_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .quotient    (quotient),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Arithmetic reference for a completed division
    task automatic ref_div(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r);
`ifdef MOD_SIGNED_EN
        logic signed [WIDTH-1:0] sx;
        logic signed [WIDTH-1:0] sy;
        sx = $signed(x);
        sy = $signed(y);
        if (x == {1'b1, {(WIDTH-1){1'b0}}} && y == '1) begin
            q = x;
            r = '0;
        end else begin
            q = sx / sy;
            r = sx % sy;
        end
`else
        q = x / y;
        r = x % y;
`endif
    endtask

    // Model: an accepted op with b!=0 completes WIDTH edges after acceptance
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cd = 0; m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_res = '0; m_quo = '0;
        end else if (m_cd > 0) begin
            m_cd--;
            m_done = 1'b0;
            if (m_cd == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_res  = p_res;
                m_quo  = p_quo;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                if (op_b == '0) begin
                    m_res = op_a; m_quo = '1; m_dbz = 1'b1; m_done = 1'b1;
                end else begin
                    m_res = '0; m_quo = '0; m_dbz = 1'b0; m_busy = 1'b1; m_cd = WIDTH;
                    ref_div(op_a, op_b, p_quo, p_res);
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            check("done", {31'b0, done}, {31'b0, m_done});
            check("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
            check("result", result, m_res);
            check("quotient", quotient, m_quo);
        end
    end

    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        start = 1'b1;
        op_a  = x;
        op_b  = y;
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int n;
        n = 0;
        last_saw_busy = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy) last_saw_busy = 1'b1;
            n = i;
            if (done) break;
        end
        check({name, "_latency"}, n, exp_lat);
    endtask

    initial begin
        logic [WIDTH-1:0] vec_a [4];
        logic [WIDTH-1:0] vec_b [4];
        int n;
        vec_a = '{32'hFFFFFFFF, 32'h80000000, 32'd12345678, 32'h7FFFFFFF};
        vec_b = '{32'd1, 32'hFFFFFFFF, 32'h00010000, 32'h7FFFFFFF};

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 100/7, then back-to-back 50/6, then back-to-back divide by zero
        issue(32'd100, 32'd7);
        wait_done(33, "t1");
        check("t1_result", result, 32'd2);
        check("t1_quotient", quotient, 32'd14);
        check("t1_dbz", {31'b0, div_by_zero}, 32'd0);
        issue(32'd50, 32'd6);
        wait_done(33, "t6");
        check("t6_result", result, 32'd2);
        check("t6_quotient", quotient, 32'd8);
        issue(32'h1234, 32'd0);
        wait_done(1, "t2");
        check("t2_result", result, 32'h1234);
        check("t2_quotient", quotient, 32'hFFFFFFFF);
        check("t2_dbz", {31'b0, div_by_zero}, 32'd1);
        check("t2_busy_seen", {31'b0, last_saw_busy}, 32'd0);
        repeat (2) @(negedge clk);

        // a<b with start held high mid-run carrying different operands
        issue(32'd5, 32'd9);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 5) begin start = 1'b1; op_a = 32'd1; op_b = 32'd1; end
            if (i == 20) start = 1'b0;
            n = i;
            if (done) break;
        end
        check("t3_latency", n, 32'd33);
        check("t3_result", result, 32'd5);
        check("t3_quotient", quotient, 32'd0);
        repeat (3) @(negedge clk);
        check("t3_hold_result", result, 32'd5);

        // Reset mid-run, then a fresh op
        issue(32'd1000, 32'd3);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_busy", {31'b0, busy}, 32'd0);
        check("t4_done", {31'b0, done}, 32'd0);
        check("t4_result", result, 32'd0);
        check("t4_quotient", quotient, 32'd0);
        rst_n = 1'b1;
        issue(32'd9, 32'd4);
        wait_done(33, "t4b");
        check("t4b_result", result, 32'd1);
        check("t4b_quotient", quotient, 32'd2);
        @(negedge clk);

        // Dividend with top bit set
        issue(32'hFFFFFFF9, 32'd3);
        wait_done(33, "t5");
`ifdef MOD_SIGNED_EN
        check("t5_result", result, 32'hFFFFFFFF);
        check("t5_quotient", quotient, 32'hFFFFFFFE);
`else
        check("t5_result", result, 32'd0);
        check("t5_quotient", quotient, 32'h55555553);
`endif
        @(negedge clk);

        // Boundary operands, checked by the model
        for (int k = 0; k < 4; k++) begin
            issue(vec_a[k], vec_b[k]);
            wait_done(33, "vec");
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
